// File: rtl/piso_serializer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_serializer_if : load handshake and serial output bundle for piso_serializer
// Revision 1.0
// ----------------------------------------------------------------------------
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] in;
   logic             shift_en;
   logic             ready;
   logic             out;
   logic             out_valid;
   logic             last;

   modport master (
      output load, in, shift_en,
      input  ready, out, out_valid, last
   );

   modport slave (
      input  load, in, shift_en,
      output ready, out, out_valid, last
   );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_serializer : parametrised PISO with valid/ready load and frame framing
// Revision 1.0
// ----------------------------------------------------------------------------
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  wire logic         clk,
   input  wire logic         rst,
   piso_serializer_if.slave  bus
);

   if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("piso_serializer: WIDTH must be in 2..64");
   end

   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q,  sreg_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             valid_q, valid_d;
   logic             last_q,  last_d;
   logic             cnt_at_last;
   logic             ready;
   logic             accept;

   assign cnt_at_last = (cnt_q == CNT_LAST);

   // Ready opens on the final bit so a waiting word follows with no bubble.
   assign ready  = rst && ((state_q == ST_IDLE) ||
                           (cnt_at_last && bus.shift_en));
   assign accept = bus.load && ready;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (accept) begin
         state_d = ST_SHIFT;
         sreg_d  = bus.in;
         cnt_d   = '0;
         valid_d = 1'b1;
         last_d  = 1'b0;
      end else if (state_q == ST_SHIFT && bus.shift_en) begin
         if (cnt_at_last) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end else begin
            if (MSB_FIRST != 0) begin
               sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end else begin
               sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
            cnt_d  = cnt_q + 1'b1;
            last_d = (cnt_q == CNT_PRE);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // The register is zero whenever idle, so its output bit doubles as `out`.
   if (MSB_FIRST != 0) begin : g_msb_out
      assign bus.out = sreg_q[WIDTH-1];
   end else begin : g_lsb_out
      assign bus.out = sreg_q[0];
   end

   assign bus.ready     = ready;
   assign bus.out_valid = valid_q;
   assign bus.last      = last_q;

endmodule
`default_nettype wire
